// File: rtl/fir8_tap_sequencer.sv
// fir8_tap_sequencer: time-multiplexed 8-tap FIR controller with one shared MAC
// Ports: ACLK/ARESETN clock and async active-low reset; s_valid/s_ready/s_data
// sample input; m_valid/m_ready/m_data result output; cfg_we/cfg_addr/cfg_data
// shadow coefficient write; cfg_commit/cfg_busy shadow-to-active commit;
// sat_flag sticky clamp indicator.
// Build option FIR_SAT_EN: shift the sum right by SHIFT and saturate m_data to DATA_W.
module fir8_tap_sequencer #(
    parameter int DATA_W = 14,
    parameter int NTAPS  = 8,
    parameter int ACC_W  = 2*DATA_W+3,
    parameter int SHIFT  = 13
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef FIR_SAT_EN
    output logic signed [DATA_W-1:0] m_data,
`else
    output logic signed [ACC_W-1:0]  m_data,
`endif
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_busy,
    output logic                     sat_flag
);
`ifdef FIR_SAT_EN
    localparam int OUT_W = DATA_W;
`else
    localparam int OUT_W = ACC_W;
`endif
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] x_q [NTAPS];
    logic signed [DATA_W-1:0] x_d [NTAPS];
    logic signed [DATA_W-1:0] sh_q [NTAPS];
    logic signed [DATA_W-1:0] sh_d [NTAPS];
    logic signed [DATA_W-1:0] act_q [NTAPS];
    logic signed [DATA_W-1:0] act_d [NTAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
    logic signed [2*DATA_W-1:0] xe, ce, prod;
    logic [2:0]               k_q, k_d;
    logic signed [OUT_W-1:0]  m_data_q, m_data_d, res;
    logic                     s_ready_q, s_ready_d, m_valid_q, m_valid_d;
    logic                     busy_q, busy_d, sat_q, sat_d, clamp;
`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0]  shifted;
`endif

    always_comb begin
        // Operands are widened first so the multiply is done at full product width.
        xe = {{DATA_W{x_q[k_q][DATA_W-1]}}, x_q[k_q]};
        ce = {{DATA_W{act_q[k_q][DATA_W-1]}}, act_q[k_q]};
        prod = xe * ce;
        sum = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`ifdef FIR_SAT_EN
        shifted = sum >>> SHIFT;
        // No clamp only when every bit above the DATA_W sign bit matches it.
        clamp = !(&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1]);
        res = !clamp ? shifted[DATA_W-1:0] :
              shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
        clamp = 1'b0;
        res = sum;
`endif
        state_d = state_q;
        x_d = x_q;
        sh_d = sh_q;
        act_d = act_q;
        acc_d = acc_q;
        k_d = k_q;
        m_data_d = m_data_q;
        m_valid_d = m_valid_q;
        sat_d = sat_q;
        busy_d = busy_q | cfg_commit;
        if (cfg_we) sh_d[cfg_addr] = cfg_data;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    // Commit edge: copy the bank, take no sample this cycle.
                    act_d = sh_q;
                    busy_d = 1'b0;
                end else if (s_valid && s_ready_q) begin
                    for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
                    x_d[0] = s_data;
                    acc_d = '0;
                    k_d = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                k_d = k_q + 3'd1;
                if (k_q == 3'(NTAPS-1)) begin
                    m_data_d = res;
                    m_valid_d = 1'b1;
                    sat_d = sat_q | clamp;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == IDLE) && !busy_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            x_q       <= '{default: '0};
            sh_q      <= '{default: '0};
            act_q     <= '{default: '0};
            acc_q     <= '0;
            k_q       <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            sh_q      <= sh_d;
            act_q     <= act_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            sat_q     <= sat_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign cfg_busy = busy_q;
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_fir8_tap_sequencer.sv
// tb_fir8_tap_sequencer: scoreboard bench for fir8_tap_sequencer
module tb_fir8_tap_sequencer;
`ifdef FIR_SAT_EN
    localparam int OW = 14;
`else
    localparam int OW = 31;
`endif
    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic signed [13:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic signed [OW-1:0] m_data;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_addr = '0;
    logic signed [13:0] cfg_data = '0;
    logic              cfg_commit = 1'b0;
    logic              cfg_busy;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    longint exp_q[$];
    int acc_cyc_q[$];
    longint mx[8], ms[8], ma[8];
    bit pend = 0;

    fir8_tap_sequencer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .sat_flag(sat_flag)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    function automatic longint fout(input longint s);
`ifdef FIR_SAT_EN
        longint t = s >>> 13;
        return t > 8191 ? 8191 : t < -8192 ? -8192 : t;
`else
        return s;
`endif
    endfunction

    task automatic cfg_write(input int a, input longint v);
        cfg_we = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = 14'(v);
        tick;
        cfg_we = 1'b0;
        ms[a] = v;
    endtask

    task automatic commit;
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        pend = 1;
    endtask

    task automatic send(input longint v);
        int n = 0;
        longint s = 0;
        while (!s_ready && n < 50) begin tick; n++; end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1);
        s_valid = 1'b1;
        s_data = 14'(v);
        tick;
        s_valid = 1'b0;
        if (pend) begin ma = ms; pend = 0; end
        for (int i = 7; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = v;
        for (int i = 0; i < 8; i++) s += mx[i] * ma[i];
        exp_q.push_back(fout(s));
        acc_cyc_q.push_back(cyc);
    endtask

    task automatic recv(input int hold);
        int n = 0;
        int a;
        longint e;
        bit ok = 1;
        m_ready = (hold == 0);
        while (!m_valid && n < 50) begin tick; n++; end
        if (!m_valid || exp_q.size() == 0) begin
            chk("m_valid_timeout", m_valid, 1);
            m_ready = 1'b1;
            return;
        end
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        chk("latency", cyc - a, 8);
        chk("m_data", m_data, e);
        repeat (hold) begin
            tick;
            if (!m_valid || m_data != e || s_ready) ok = 0;
        end
        if (hold > 0) chk("hold_stable", ok, 1);
        m_ready = 1'b1;
        tick;
        chk("m_valid_drop", m_valid, 0);
    endtask

    task automatic xfer(input longint v);
        send(v);
        recv(0);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 8; i++) begin mx[i] = 0; ms[i] = 0; ma[i] = 0; end
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_cfg_busy", cfg_busy, 0);
        chk("rst_sat_flag", sat_flag, 0);
        tick;
        ARESETN = 1'b1;
        tick;
        // impulse with coefficients 1..8
        for (int i = 0; i < 8; i++) cfg_write(i, i + 1);
        commit;
        chk("busy_after_commit", cfg_busy, 1);
        chk("s_ready_while_busy", s_ready, 0);
        send(1);
        a0 = acc_cyc_q[0];
        recv(0);
        send(0);
        chk("throughput", acc_cyc_q[0] - a0, 10);
        recv(0);
        for (int i = 0; i < 6; i++) xfer(0);
        // step response, positive then negative
        for (int i = 0; i < 8; i++) cfg_write(i, 3);
        commit;
        for (int i = 0; i < 10; i++) xfer(100);
        for (int i = 0; i < 10; i++) xfer(-100);
        // commit while a sample is in the MAC phase
        for (int i = 0; i < 8; i++) cfg_write(i, 1);
        commit;
        for (int i = 0; i < 8; i++) xfer(10);
        for (int i = 0; i < 8; i++) cfg_write(i, 2);
        send(10);
        tick; tick; tick;
        commit;
        chk("busy_mid_mac", cfg_busy, 1);
        recv(0);
        chk("s_ready_copy_cycle", s_ready, 0);
        chk("busy_before_copy", cfg_busy, 1);
        tick;
        chk("busy_after_copy", cfg_busy, 0);
        chk("s_ready_after_copy", s_ready, 1);
        xfer(10);
        // backpressure
        send(5);
        recv(20);
        chk("s_ready_after_bp", s_ready, 1);
        // reset at tap 4
        send(7);
        repeat (4) tick;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_data", m_data, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin mx[i] = 0; ms[i] = 0; ma[i] = 0; end
        pend = 0;
        tick;
        ARESETN = 1'b1;
        tick;
        xfer(1);
`ifdef FIR_SAT_EN
        for (int i = 0; i < 8; i++) cfg_write(i, 8191);
        commit;
        for (int i = 0; i < 8; i++) xfer(8191);
        chk("sat_flag_set", sat_flag, 1);
        for (int i = 0; i < 8; i++) xfer(-8192);
        chk("sat_flag_sticky", sat_flag, 1);
`else
        chk("sat_flag_zero", sat_flag, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
